result_writeback_sequencer: RTL

Drain-side companion to the nested row/tile index counter that feeds the systolic array. Accepts result beats from the array's output edge over a valid/ready stream and converts them into a sequenced memory write stream: one write per beat, addressed by (tile, row) nested counters. Configured per job by a start pulse, and signals completion so the controller can launch the next job.

---
 rtl/tpu_wb_pkg.sv | 17 +
 rtl/wb_nested_counter.sv | 64 ++++++
 rtl/result_writeback_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/tpu_wb_pkg.sv
// Shared types and default widths for the result writeback sequencer.
// The state encoding is used by the top-level FSM; the widths act as parameter defaults.
package tpu_wb_pkg;

    localparam int DEF_COLS   = 4;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_nested_counter.sv
// Holds the (tile, row) position of the next accepted beat, plus the running tile base address.
// State updates on the clock edge after load/advance; the address and flag outputs are combinational.
module wb_nested_counter
    import tpu_wb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_num_rows,
    input  logic [CNT_W-1:0]  cfg_num_tiles,
    input  logic [ADDR_W-1:0] cfg_tile_stride,
    input  logic              advance,
    output logic [CNT_W-1:0]  row_idx,
    output logic [CNT_W-1:0]  tile_idx,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              row_last,
    output logic              last_beat
);
    logic [CNT_W-1:0]  num_rows;
    logic [CNT_W-1:0]  num_tiles;
    logic [ADDR_W-1:0] tile_stride;
    logic [ADDR_W-1:0] tile_base;
    logic              tile_last;

    assign row_last  = (row_idx == num_rows - CNT_W'(1));
    assign tile_last = (tile_idx == num_tiles - CNT_W'(1));
    assign last_beat = row_last && tile_last;
    // Address arithmetic deliberately wraps modulo 2^ADDR_W.
    assign beat_addr = tile_base + ADDR_W'(row_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_rows    <= '0;
            num_tiles   <= '0;
            tile_stride <= '0;
            tile_base   <= '0;
            row_idx     <= '0;
            tile_idx    <= '0;
        end else if (load) begin
            num_rows    <= cfg_num_rows;
            num_tiles   <= cfg_num_tiles;
            tile_stride <= cfg_tile_stride;
            tile_base   <= cfg_base_addr;
            row_idx     <= '0;
            tile_idx    <= '0;
        end else if (advance) begin
            if (last_beat) begin
                row_idx  <= '0;
                tile_idx <= '0;
            end else if (row_last) begin
                row_idx   <= '0;
                tile_idx  <= tile_idx + CNT_W'(1);
                tile_base <= tile_base + tile_stride;
            end else begin
                row_idx <= row_idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_writeback_sequencer.sv
// Turns accepted result beats into addressed memory writes through a single output slot; in_data reaches mem_wdata one cycle after accept.
// in_ready drops when the slot is full and memory stalls (combinational on mem_ready); a drain and a new accept can share a cycle.
module result_writeback_sequencer
    import tpu_wb_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [CNT_W-1:0]      cfg_num_rows,
    input  logic [CNT_W-1:0]      cfg_num_tiles,
    input  logic [ADDR_W-1:0]     cfg_tile_stride,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COLS*ACC_W-1:0] in_data,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [COLS*ACC_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]      row_idx,
    output logic [CNT_W-1:0]      tile_idx,
    output logic                  last_row,
    output logic                  busy,
    output logic                  done
);
    wb_state_t         state;
    wb_state_t         state_nxt;
    logic              accept;
    logic              load;
    logic              row_last;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;

    assign in_ready = (state == ST_RUN) && (!mem_we || mem_ready);
    assign accept   = in_valid && in_ready;
    assign load     = (state == ST_IDLE) && start;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign last_row = busy && row_last;

    wb_nested_counter #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (load),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_num_rows    (cfg_num_rows),
        .cfg_num_tiles   (cfg_num_tiles),
        .cfg_tile_stride (cfg_tile_stride),
        .advance         (accept),
        .row_idx         (row_idx),
        .tile_idx        (tile_idx),
        .beat_addr       (beat_addr),
        .row_last        (row_last),
        .last_beat       (last_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // An empty job skips straight to completion without writing.
                    if (cfg_num_rows == '0 || cfg_num_tiles == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept && last_beat) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (mem_we && mem_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= beat_addr;
            mem_wdata <= in_data;
        end else if (mem_we && mem_ready) begin
            mem_we <= 1'b0;
        end
    end

endmodule
